sprite_line_scheduler: RTL and testbench
========================================

# sprite_line_scheduler

Per-scanline sprite scheduler that shares the single sprite frame ROM among up to NUM_SPRITES sprites. During horizontal blanking it fetches the next line's sprite palette indices from the ROM into a ping-pong line buffer, resolving priority and transparency. During active display it streams the current line's resolved palette index to the palette/colour stage, which drives R, G, B.

## Interface
Parameters:
- NUM_SPRITES, 4, sprites scheduled per line; sprite 0 has highest priority
- SPR_W, 16, sprite width in pixels (power of two)
- SPR_H, 16, sprite height in lines
- ADDR_W, 20, frame ROM address width
- IDX_W, 4, palette index width; index 0 is transparent

Ports:
- Clk  in  1  pixel clock
- Reset  in  1  asynchronous, active-high
- line_start  in  1  one-cycle pulse at the start of hblank; begins fetch for line_y
- line_y  in  10  scanline being prepared; sampled on line_start
- drawX  in  10  current display column; valid while < 640
- spr_en  in  NUM_SPRITES  per-sprite enable; sampled during SCAN
- spr_x  in  NUM_SPRITES*10  sprite left column, sprite i at [10i+9:10i]
- spr_y  in  NUM_SPRITES*10  sprite top row
- spr_base  in  NUM_SPRITES*ADDR_W  ROM address of the sprite's pixel (0,0), row-major
- rom_addr  out  ADDR_W  frame ROM read address
- rom_rd  out  1  rom_addr is valid this cycle
- rom_data  in  IDX_W  ROM data; synchronous, valid one cycle after rom_rd
- pix_index  out  IDX_W  resolved palette index for drawX of the previous cycle
- pix_opaque  out  1  pix_index != 0 and output is qualified
- busy  out  1  FSM not in IDLE
- overrun  out  1  sticky; set when line_start arrives while busy

## Operation
- Storage: two line buffers, 640 x IDX_W each. wsel selects the fetch buffer; the other is the display buffer.
- On line_start: wsel toggles, line_y is latched, and the FSM enters SCAN.
- FSM states: IDLE, SCAN, FETCH, DRAIN.
  - SCAN: one cycle per sprite. The sprite order is descending, i = NUM_SPRITES-1 down to 0. Sprite i hits iff spr_en[i], line_y >= spr_y[i], and line_y - spr_y[i] < SPR_H. Hits are pushed into a hit mask; the scan then goes to FETCH on the highest-numbered hit. With no hits it returns to IDLE.
  - FETCH: for the current hit sprite, issue SPR_W consecutive reads. Each read has rom_rd = 1 and rom_addr = spr_base + row*SPR_W + col, where row = line_y - spr_y and col = 0..SPR_W-1. The address is computed mod 2^ADDR_W. After the last col, advance to the next lower-numbered hit with no bubble. After the last hit, go to DRAIN.
  - DRAIN: one cycle to capture the final rom_data, then IDLE.
- Capture: one cycle after each read, if rom_data != 0 and x = spr_x + col (11-bit) < 640, write rom_data to fetch buffer[x].
  - Transparent pixels and off-screen pixels are dropped.
- Priority: sprites are fetched high-numbered first, so lower-numbered sprites overwrite higher ones. No read-modify-write is needed.
- Display: each cycle with drawX < 640, read display buffer[drawX] into pix_index (registered) and write 0 to that entry in the same cycle. This clear-on-read leaves the buffer empty for reuse.
  - For drawX >= 640: pix_index = 0.
- Qualification: a 2-bit counter counts line_start pulses after reset, saturating at 2. Until it saturates, pix_index = 0 and pix_opaque = 0, because buffer contents are undefined after reset.
- Overrun: if line_start arrives in a state other than IDLE:
  - abort the fetch, set overrun, toggle wsel, and restart at SCAN for the new line_y;
  - any pixels not yet fetched are lost.
  - overrun is cleared only by Reset.

## Timing
- Reset values: state IDLE, wsel 0, rom_addr 0, rom_rd 0, pix_index 0, pix_opaque 0, busy 0, overrun 0, qualification counter 0.
- busy rises the cycle after line_start.
- Fetch length is NUM_SPRITES + H*SPR_W + 1 cycles, where H is the number of hit sprites. Worst case with defaults is 69 cycles, within the 160-cycle hblank.
- ROM read to buffer write takes 1 cycle. The final write lands in DRAIN.
- Display latency is 1 cycle: pix_index at cycle n+1 reflects drawX at cycle n.
- A simultaneous fetch write and display read never target the same buffer, since wsel separates them.
- Sprite inputs are sampled during SCAN/FETCH. Changes mid-line take effect on the next line_start.

## Test plan
- Single sprite 0 at (100,50), base 0x00100, ROM index = col+1, line_y=52: 16 reads at 0x00120..0x0012F. On the next line, pix_index = 1..16 mod 16 at drawX 100..115 (col 15 reads 0, transparent), and 0 elsewhere.
- Sprites 0 and 1 both at x=200 on the same line, with sprite 1 all 5 and sprite 0 all 3 except col 4 = 0: pixel 204 = 5, other pixels 200..215 = 3. Fetch order is sprite 1 then sprite 0.
- Sprite at spr_x=630: columns 0..9 are written; columns 10..15 produce no write and no error.
- line_y=66 with spr_y=50 (row 16), and line_y=49: no hits, busy lasts SCAN only (4 cycles), and no rom_rd.
- line_start while in FETCH: overrun = 1 and stays 1, fetch restarts for the new line_y, and Reset clears overrun.
- Assert Reset mid-FETCH: all outputs go to 0 immediately. pix_opaque stays 0 until the second line_start after Reset.

Source files
------------

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler: fetches next-line sprite pixels from a shared frame ROM into a
// ping-pong line buffer during hblank, and streams the resolved palette index during display.
module sprite_line_scheduler #(
    parameter int unsigned NUM_SPRITES = 4,
    parameter int unsigned SPR_W       = 16,
    parameter int unsigned SPR_H       = 16,
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned IDX_W       = 4
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          line_start,
    input  logic [9:0]                    line_y,
    input  logic [9:0]                    drawX,
    input  logic [NUM_SPRITES-1:0]        spr_en,
    input  logic [NUM_SPRITES*10-1:0]     spr_x,
    input  logic [NUM_SPRITES*10-1:0]     spr_y,
    input  logic [NUM_SPRITES*ADDR_W-1:0] spr_base,
    output logic [ADDR_W-1:0]             rom_addr,
    output logic                          rom_rd,
    input  logic [IDX_W-1:0]              rom_data,
    output logic [IDX_W-1:0]              pix_index,
    output logic                          pix_opaque,
    output logic                          busy,
    output logic                          overrun
);

    localparam int unsigned LINE_W = 640;
    localparam int unsigned SEL_W  = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int unsigned COL_W  = (SPR_W > 1) ? $clog2(SPR_W) : 1;

    typedef enum logic [1:0] {StIdle, StScan, StFetch, StDrain} state_e;

    state_e                   state_q, state_d;
    logic                     wsel_q, wsel_d;
    logic [9:0]               line_y_q, line_y_d;
    logic [SEL_W-1:0]         scan_idx_q, scan_idx_d;
    logic [NUM_SPRITES-1:0]   hit_mask_q, hit_mask_d;
    logic [SEL_W-1:0]         cur_q, cur_d;
    logic [COL_W-1:0]         col_q, col_d;
    logic                     cap_valid_q, cap_valid_d;
    logic [10:0]              cap_x_q, cap_x_d;
    logic [1:0]               qual_q, qual_d;
    logic                     overrun_q, overrun_d;
    logic [IDX_W-1:0]         pix_index_q, pix_index_d;
    logic                     pix_opaque_q, pix_opaque_d;

    logic [9:0]               sx    [NUM_SPRITES];
    logic [9:0]               sy    [NUM_SPRITES];
    logic [ADDR_W-1:0]        sbase [NUM_SPRITES];

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_unpack
        assign sx[g]    = spr_x[g*10 +: 10];
        assign sy[g]    = spr_y[g*10 +: 10];
        assign sbase[g] = spr_base[g*ADDR_W +: ADDR_W];
    end

    // Highest-numbered set bit: fetch order runs from low priority to high priority.
    function automatic logic [SEL_W-1:0] top_hit(input logic [NUM_SPRITES-1:0] m);
        logic [SEL_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (m[i]) r = SEL_W'(i);
        end
        return r;
    endfunction

    logic [9:0]             scan_dy;
    logic                   scan_hit;
    logic [9:0]             fetch_row;
    logic [ADDR_W-1:0]      fetch_addr;
    logic [NUM_SPRITES-1:0] scan_mask;
    logic [NUM_SPRITES-1:0] rem_mask;

    always_comb begin
        scan_dy    = line_y_q - sy[scan_idx_q];
        scan_hit   = spr_en[scan_idx_q] && (line_y_q >= sy[scan_idx_q]) &&
                     (scan_dy < 10'(SPR_H));
        fetch_row  = line_y_q - sy[cur_q];
        fetch_addr = sbase[cur_q] + ADDR_W'(fetch_row) * ADDR_W'(SPR_W) + ADDR_W'(col_q);
    end

    always_comb begin
        state_d      = state_q;
        wsel_d       = wsel_q;
        line_y_d     = line_y_q;
        scan_idx_d   = scan_idx_q;
        hit_mask_d   = hit_mask_q;
        cur_d        = cur_q;
        col_d        = col_q;
        cap_valid_d  = 1'b0;
        cap_x_d      = {1'b0, sx[cur_q]} + 11'(col_q);
        qual_d       = qual_q;
        overrun_d    = overrun_q;
        scan_mask    = hit_mask_q;
        rem_mask     = hit_mask_q;

        unique case (state_q)
            StIdle: ;
            StScan: begin
                scan_mask[scan_idx_q] = scan_mask[scan_idx_q] | scan_hit;
                hit_mask_d = scan_mask;
                if (scan_idx_q == '0) begin
                    if (|scan_mask) begin
                        state_d = StFetch;
                        cur_d   = top_hit(scan_mask);
                        col_d   = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    scan_idx_d = scan_idx_q - 1'b1;
                end
            end
            StFetch: begin
                cap_valid_d = 1'b1;
                if (col_q == COL_W'(SPR_W - 1)) begin
                    rem_mask[cur_q] = 1'b0;
                    hit_mask_d = rem_mask;
                    col_d      = '0;
                    if (|rem_mask) begin
                        cur_d = top_hit(rem_mask);
                    end else begin
                        state_d = StDrain;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            StDrain: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // A new line always wins; an in-flight fetch is abandoned and its pending capture dropped.
        if (line_start) begin
            if (state_q != StIdle) overrun_d = 1'b1;
            state_d     = StScan;
            wsel_d      = ~wsel_q;
            line_y_d    = line_y;
            scan_idx_d  = SEL_W'(NUM_SPRITES - 1);
            hit_mask_d  = '0;
            col_d       = '0;
            cap_valid_d = 1'b0;
            if (qual_q != 2'd2) qual_d = qual_q + 2'd1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= StIdle;
            wsel_q       <= 1'b0;
            line_y_q     <= '0;
            scan_idx_q   <= '0;
            hit_mask_q   <= '0;
            cur_q        <= '0;
            col_q        <= '0;
            cap_valid_q  <= 1'b0;
            cap_x_q      <= '0;
            qual_q       <= '0;
            overrun_q    <= 1'b0;
            pix_index_q  <= '0;
            pix_opaque_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wsel_q       <= wsel_d;
            line_y_q     <= line_y_d;
            scan_idx_q   <= scan_idx_d;
            hit_mask_q   <= hit_mask_d;
            cur_q        <= cur_d;
            col_q        <= col_d;
            cap_valid_q  <= cap_valid_d;
            cap_x_q      <= cap_x_d;
            qual_q       <= qual_d;
            overrun_q    <= overrun_d;
            pix_index_q  <= pix_index_d;
            pix_opaque_q <= pix_opaque_d;
        end
    end

    logic [IDX_W-1:0] buf0 [LINE_W];
    logic [IDX_W-1:0] buf1 [LINE_W];
    logic             fetch_we;
    logic             disp_re;
    logic [9:0]       disp_addr;
    logic [IDX_W-1:0] disp_data;

    always_comb begin
        fetch_we  = cap_valid_q && (rom_data != '0) && (cap_x_q < 11'd640);
        disp_re   = drawX < 10'd640;
        disp_addr = disp_re ? drawX : '0;
        disp_data = wsel_q ? buf0[disp_addr] : buf1[disp_addr];
    end

    // wsel selects the fetch buffer; the other buffer is read and cleared by the display.
    always_ff @(posedge Clk) begin
        if (!wsel_q) begin
            if (fetch_we) buf0[cap_x_q[9:0]] <= rom_data;
            if (disp_re)  buf1[disp_addr]    <= '0;
        end else begin
            if (fetch_we) buf1[cap_x_q[9:0]] <= rom_data;
            if (disp_re)  buf0[disp_addr]    <= '0;
        end
    end

    always_comb begin
        pix_index_d  = (disp_re && qual_q == 2'd2) ? disp_data : '0;
        pix_opaque_d = pix_index_d != '0;
    end

    assign rom_rd     = state_q == StFetch;
    assign rom_addr   = rom_rd ? fetch_addr : '0;
    assign busy       = state_q != StIdle;
    assign overrun    = overrun_q;
    assign pix_index  = pix_index_q;
    assign pix_opaque = pix_opaque_q;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Directed bench for sprite_line_scheduler: ROM read sequences, line-buffer contents on display,
// priority, clipping, overrun and reset/qualification behaviour.
module tb_sprite_line_scheduler;

    localparam int N = 4;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          line_start = 1'b0;
    logic [9:0]    line_y = '0;
    logic [9:0]    drawX = 10'd700;
    logic [N-1:0]  spr_en = '0;
    logic [N*10-1:0] spr_x = '0;
    logic [N*10-1:0] spr_y = '0;
    logic [N*20-1:0] spr_base = '0;
    logic [19:0]   rom_addr;
    logic          rom_rd;
    logic [3:0]    rom_data;
    logic [3:0]    pix_index;
    logic          pix_opaque;
    logic          busy;
    logic          overrun;

    sprite_line_scheduler dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .line_start (line_start),
        .line_y     (line_y),
        .drawX      (drawX),
        .spr_en     (spr_en),
        .spr_x      (spr_x),
        .spr_y      (spr_y),
        .spr_base   (spr_base),
        .rom_addr   (rom_addr),
        .rom_rd     (rom_rd),
        .rom_data   (rom_data),
        .pix_index  (pix_index),
        .pix_opaque (pix_opaque),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 Clk = ~Clk;

    // ROM image: page 0 holds col+1, page 1 all 5, page 2 all 3 except col 4, others all 7.
    function automatic logic [3:0] rom_fn(input logic [19:0] a);
        case (a[19:12])
            8'h00:   return a[3:0] + 4'd1;
            8'h01:   return 4'd5;
            8'h02:   return (a[3:0] == 4'd4) ? 4'd0 : 4'd3;
            default: return 4'd7;
        endcase
    endfunction

    always @(posedge Clk) begin
        if (Reset)       rom_data <= 4'd0;
        else if (rom_rd) rom_data <= rom_fn(rom_addr);
    end

    logic [19:0] rd_q [$];
    always @(negedge Clk) if (rom_rd) rd_q.push_back(rom_addr);

    int n_checks = 0;
    int n_fail = 0;
    int ls_count = 0;
    int cyc;
    logic [3:0] got_idx [640];
    logic       got_opq [640];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_spr(input int i, input logic [9:0] x, input logic [9:0] y,
                           input logic [19:0] base);
        spr_en[i] = 1'b1;
        spr_x[i*10 +: 10] = x;
        spr_y[i*10 +: 10] = y;
        spr_base[i*20 +: 20] = base;
    endtask

    task automatic start_line(input logic [9:0] y);
        line_start = 1'b1;
        line_y = y;
        ls_count++;
        tick();
        line_start = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 300) begin
            n++;
            tick();
        end
        if (busy) check_eq("idle_timeout", {31'b0, busy}, 32'd0);
    endtask

    task automatic sweep();
        for (int x = 0; x < 640; x++) begin
            drawX = 10'(x);
            tick();
            got_idx[x] = pix_index;
            got_opq[x] = pix_opaque;
        end
        drawX = 10'd700;
        tick();
    endtask

    task automatic check_addr(input string tag, input int k, input logic [19:0] exp);
        if (rd_q.size() > k) check_eq(tag, {12'b0, rd_q[k]}, {12'b0, exp});
        else check_eq({tag, "_missing"}, rd_q.size(), k + 1);
    endtask

    initial begin
        repeat (2) tick();
        check_eq("rst_busy", {31'b0, busy}, 0);
        check_eq("rst_overrun", {31'b0, overrun}, 0);
        check_eq("rst_rom_rd", {31'b0, rom_rd}, 0);
        check_eq("rst_rom_addr", {12'b0, rom_addr}, 0);
        check_eq("rst_pix_index", {28'b0, pix_index}, 0);
        check_eq("rst_pix_opaque", {31'b0, pix_opaque}, 0);
        Reset = 1'b0;
        tick();

        // No hits: row 16 (below sprite) and line above sprite.
        set_spr(0, 10'd100, 10'd50, 20'h00100);
        rd_q.delete();
        start_line(10'd66);
        cyc = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy) cyc++;
            tick();
        end
        check_eq("nohit66_busy", cyc, 4);
        check_eq("nohit66_reads", rd_q.size(), 0);
        sweep();
        start_line(10'd49);
        cyc = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy) cyc++;
            tick();
        end
        check_eq("nohit49_busy", cyc, 4);
        check_eq("nohit49_reads", rd_q.size(), 0);
        sweep();

        // Single sprite, row 2.
        rd_q.delete();
        start_line(10'd52);
        wait_idle(cyc);
        check_eq("t1_fetch_len", cyc, 21);
        check_eq("t1_reads", rd_q.size(), 16);
        for (int c = 0; c < 16; c++) check_addr("t1_addr", c, 20'h00120 + 20'(c));
        spr_en = '0;
        start_line(10'd53);
        wait_idle(cyc);
        sweep();
        check_eq("t1_px99", got_idx[99], 0);
        check_eq("t1_px100", got_idx[100], 1);
        check_eq("t1_px107", got_idx[107], 8);
        check_eq("t1_px114", got_idx[114], 15);
        check_eq("t1_px115", got_idx[115], 0);
        check_eq("t1_px116", got_idx[116], 0);
        check_eq("t1_opq100", got_opq[100], 1);
        check_eq("t1_opq115", got_opq[115], 0);
        check_eq("t1_offscreen", {28'b0, pix_index}, 0);

        // Overlapping sprites: sprite 1 fetched first, sprite 0 overwrites except col 4.
        spr_en = '0;
        set_spr(0, 10'd200, 10'd80, 20'h02000);
        set_spr(1, 10'd200, 10'd80, 20'h01000);
        rd_q.delete();
        start_line(10'd80);
        wait_idle(cyc);
        check_eq("t2_fetch_len", cyc, 37);
        check_eq("t2_reads", rd_q.size(), 32);
        check_addr("t2_first", 0, 20'h01000);
        check_addr("t2_s1_last", 15, 20'h0100F);
        check_addr("t2_s0_first", 16, 20'h02000);
        check_addr("t2_last", 31, 20'h0200F);
        spr_en = '0;
        start_line(10'd81);
        wait_idle(cyc);
        sweep();
        check_eq("t2_px199", got_idx[199], 0);
        check_eq("t2_px200", got_idx[200], 3);
        check_eq("t2_px204", got_idx[204], 5);
        check_eq("t2_px205", got_idx[205], 3);
        check_eq("t2_px215", got_idx[215], 3);
        check_eq("t2_px216", got_idx[216], 0);

        // Right-edge clipping.
        set_spr(2, 10'd630, 10'd10, 20'h03000);
        rd_q.delete();
        start_line(10'd10);
        wait_idle(cyc);
        check_eq("t3_fetch_len", cyc, 21);
        check_eq("t3_reads", rd_q.size(), 16);
        check_addr("t3_last", 15, 20'h0300F);
        spr_en = '0;
        start_line(10'd11);
        wait_idle(cyc);
        sweep();
        check_eq("t3_px629", got_idx[629], 0);
        check_eq("t3_px630", got_idx[630], 7);
        check_eq("t3_px639", got_idx[639], 7);
        check_eq("t3_px0", got_idx[0], 0);

        // Overrun mid-fetch restarts on the new line.
        set_spr(0, 10'd100, 10'd50, 20'h00100);
        start_line(10'd52);
        repeat (8) tick();
        check_eq("t5_in_fetch", {31'b0, rom_rd}, 1);
        check_eq("t5_ovr_before", {31'b0, overrun}, 0);
        start_line(10'd53);
        check_eq("t5_ovr_set", {31'b0, overrun}, 1);
        rd_q.delete();
        wait_idle(cyc);
        check_eq("t5_fetch_len", cyc, 21);
        check_eq("t5_reads", rd_q.size(), 16);
        check_addr("t5_first", 0, 20'h00130);
        check_eq("t5_ovr_sticky", {31'b0, overrun}, 1);

        // Leave sprite pixels in buffer 0, then reset mid-fetch of the following line.
        if (ls_count % 2 == 0) begin
            start_line(10'd60);
            wait_idle(cyc);
        end
        start_line(10'd52);
        wait_idle(cyc);
        start_line(10'd52);
        repeat (8) tick();
        Reset = 1'b1;
        #1;
        check_eq("t6_busy", {31'b0, busy}, 0);
        check_eq("t6_rom_rd", {31'b0, rom_rd}, 0);
        check_eq("t6_rom_addr", {12'b0, rom_addr}, 0);
        check_eq("t6_overrun", {31'b0, overrun}, 0);
        check_eq("t6_pix_index", {28'b0, pix_index}, 0);
        tick();
        Reset = 1'b0;
        ls_count = 0;
        tick();
        start_line(10'd52);
        wait_idle(cyc);
        sweep();
        check_eq("t6_unqual_px100", got_idx[100], 0);
        check_eq("t6_unqual_opq100", got_opq[100], 0);
        spr_en = '0;
        start_line(10'd53);
        wait_idle(cyc);
        sweep();
        check_eq("t6_qual_px100", got_idx[100], 1);
        check_eq("t6_qual_opq100", got_opq[100], 1);
        check_eq("t6_qual_px114", got_idx[114], 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

endmodule
